// File: rtl/irq_encoder8to3_pkg.sv
// Shared constants, FSM state type and one-hot helper for the IRQ encoder.
package enc_pkg;
    localparam int NUM_REQ = 8;
    localparam int CODE_W  = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // One-hot expansion of a 3-bit code, used to clear the served bit.
    function automatic logic [NUM_REQ-1:0] onehot8(input logic [CODE_W-1:0] code);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << code;
    endfunction
endpackage

// File: rtl/irq_encoder8to3_prio_enc8.sv
// Combinational 8-bit priority encoder; the highest set bit wins.
module prio_enc8
    import enc_pkg::*;
(
    input  logic [NUM_REQ-1:0] vec,
    output logic [CODE_W-1:0]  idx,
    output logic               any
);
    // Scan from low to high so the last hit (highest bit) is kept.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (vec[i]) begin
                idx = CODE_W'(i);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/irq_encoder8to3.sv
// Registered 8-to-3 priority encoder with edge latching and valid/ack handshake.
module irq_encoder8to3
    import enc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic               ack,
    output logic [CODE_W-1:0]  out,
    output logic               valid,
    output logic [NUM_REQ-1:0] pending,
    output logic               lost
);
    logic [NUM_REQ-1:0] req_q;
    logic [NUM_REQ-1:0] rise;
    logic [NUM_REQ-1:0] clear;
    logic [CODE_W-1:0]  idx;
    logic               any;
    logic [CODE_W-1:0]  out_n;
    logic               valid_n;
    state_t             state, state_n;

    // The encoder only ever sees the registered pending vector, never this cycle's edges.
    prio_enc8 u_prio (
        .vec (pending & ~mask),
        .idx (idx),
        .any (any)
    );

    // Edge detect and the clear vector for the code being accepted this cycle.
    always_comb begin
        rise  = req & ~req_q;
        clear = (ack && valid && en) ? onehot8(out) : '0;
    end

    // Next-state logic: latch a code in IDLE, hold it frozen in PRESENT until ack or en drops.
    always_comb begin
        state_n = state;
        out_n   = out;
        valid_n = valid;
        case (state)
            IDLE: begin
                valid_n = 1'b0;
                if (en && any) begin
                    out_n   = idx;
                    valid_n = 1'b1;
                    state_n = PRESENT;
                end
            end
            PRESENT: begin
                if (!en || ack) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                valid_n = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // State, edge-detect, pending and lost registers; set beats clear on the same bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            req_q   <= '0;
            pending <= '0;
            out     <= '0;
            valid   <= 1'b0;
            lost    <= 1'b0;
        end else begin
            state   <= state_n;
            req_q   <= req;
            pending <= (pending & ~clear) | rise;
            out     <= out_n;
            valid   <= valid_n;
            lost    <= |(rise & pending & ~clear);
        end
    end
endmodule

// File: tb/tb_irq_encoder8to3.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_irq_encoder8to3;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic [2:0] out;
    logic       valid;
    logic [7:0] pending;
    logic       lost;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit [7:0] m_pend, m_reqq;
    int       m_out;
    bit       m_valid, m_lost;

    irq_encoder8to3 dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .mask(mask), .ack(ack),
        .out(out), .valid(valid), .pending(pending), .lost(lost)
    );

    always #5 clk = ~clk;

    function automatic int highest(input bit [7:0] v);
        int h = -1;
        for (int i = 7; i >= 0; i--) if (v[i] && h < 0) h = i;
        return h;
    endfunction

    // Model of one clock edge, written from the event/grant rules.
    task automatic model_step();
        bit [7:0] rise, clr, elig;
        if (!rst_n) begin
            m_pend = 0; m_reqq = 0; m_out = 0; m_valid = 0; m_lost = 0;
        end else begin
            rise = req & ~m_reqq;
            clr  = (ack && m_valid && en) ? 8'(1 << m_out) : 8'h00;
            m_lost = (rise & m_pend & ~clr) != 0;
            elig = m_pend & ~mask;
            if (!m_valid) begin
                if (en && elig != 0) begin
                    m_out = highest(elig);
                    m_valid = 1;
                end
            end else if (!en || ack) begin
                m_valid = 0;
            end
            m_pend = (m_pend & ~clr) | rise;
            m_reqq = req;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; en = 0; req = 8'h01; mask = 0; ack = 0;
        tick(); tick();
        checks++;
        if ({out, valid, pending, lost} !== 13'd0) begin
            errors++;
            $display("FAIL reset: out=%0d valid=%b pending=%h lost=%b required all zero", out, valid, pending, lost);
        end
        rst_n = 1;
        tick();
        checks++;
        if (pending !== 8'h01) begin
            errors++;
            $display("FAIL reset_held_req: pending=%h required 01", pending);
        end
        req = 0; rst_n = 0; tick(); rst_n = 1;
    endtask

    task automatic test_single();
        en = 1; req = 8'h04; tick();
        req = 0;
        checks++;
        if (valid !== 1'b0 || pending !== 8'h04) begin
            errors++;
            $display("FAIL single_k: valid=%b pending=%h required 0/04", valid, pending);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || out !== 3'd2) begin
            errors++;
            $display("FAIL single_grant: valid=%b out=%0d required 1/2", valid, out);
        end
        ack = 1; tick(); ack = 0;
        checks++;
        if (valid !== 1'b0 || pending !== 8'h00) begin
            errors++;
            $display("FAIL single_ack: valid=%b pending=%h required 0/00", valid, pending);
        end
    endtask

    task automatic test_priority();
        int exp_seq[6] = '{7, -1, 5, -1, 1, -1};
        req = 8'hA2; tick(); req = 0; tick();
        ack = 1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (exp_seq[i] < 0 ? (valid !== 1'b0) : (valid !== 1'b1 || out !== 3'(exp_seq[i]))) begin
                errors++;
                $display("FAIL priority_%0d: valid=%b out=%0d required grant %0d", i, valid, out, exp_seq[i]);
            end
            tick();
        end
        ack = 0;
        checks++;
        if (pending !== 8'h00 || valid !== 1'b0) begin
            errors++;
            $display("FAIL priority_done: pending=%h valid=%b required 00/0", pending, valid);
        end
    endtask

    task automatic test_no_preempt();
        req = 8'h08; tick(); req = 0; tick();
        req = 8'h40; tick(); req = 0; tick();
        checks++;
        if (valid !== 1'b1 || out !== 3'd3 || pending !== 8'h48) begin
            errors++;
            $display("FAIL no_preempt: valid=%b out=%0d pending=%h required 1/3/48", valid, out, pending);
        end
        ack = 1; tick(); ack = 0; tick();
        checks++;
        if (valid !== 1'b1 || out !== 3'd6) begin
            errors++;
            $display("FAIL after_preempt: valid=%b out=%0d required 1/6", valid, out);
        end
        ack = 1; tick(); ack = 0;
    endtask

    task automatic test_mask();
        mask = 8'h80; req = 8'h84; tick(); req = 0; tick();
        checks++;
        if (valid !== 1'b1 || out !== 3'd2) begin
            errors++;
            $display("FAIL mask_grant: valid=%b out=%0d required 1/2", valid, out);
        end
        ack = 1; tick(); ack = 0; mask = 0;
        checks++;
        if (pending !== 8'h80) begin
            errors++;
            $display("FAIL mask_retain: pending=%h required 80", pending);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || out !== 3'd7) begin
            errors++;
            $display("FAIL unmask_grant: valid=%b out=%0d required 1/7", valid, out);
        end
        ack = 1; tick(); ack = 0;
    endtask

    task automatic test_lost();
        req = 8'h10; tick(); req = 0; tick();
        req = 8'h10; tick();
        checks++;
        if (lost !== 1'b1) begin
            errors++;
            $display("FAIL lost_pulse: lost=%b required 1", lost);
        end
        req = 0; tick();
        checks++;
        if (lost !== 1'b0 || valid !== 1'b1 || out !== 3'd4) begin
            errors++;
            $display("FAIL lost_end: lost=%b valid=%b out=%0d required 0/1/4", lost, valid, out);
        end
        req = 8'h10; ack = 1; tick(); ack = 0; req = 0;
        checks++;
        if (lost !== 1'b0 || pending !== 8'h10 || valid !== 1'b0) begin
            errors++;
            $display("FAIL set_wins: lost=%b pending=%h valid=%b required 0/10/0", lost, pending, valid);
        end
        tick(); ack = 1; tick(); ack = 0;
    endtask

    task automatic test_en_drop();
        req = 8'h21; tick(); req = 0; tick();
        en = 0; ack = 1; tick();
        checks++;
        if (valid !== 1'b0 || pending !== 8'h21) begin
            errors++;
            $display("FAIL en_drop: valid=%b pending=%h required 0/21", valid, pending);
        end
        en = 1; ack = 0; tick();
        checks++;
        if (valid !== 1'b1 || out !== 3'd5) begin
            errors++;
            $display("FAIL en_resume: valid=%b out=%0d required 1/5", valid, out);
        end
        rst_n = 0; tick(); rst_n = 1;
        checks++;
        if ({out, valid, pending, lost} !== 13'd0) begin
            errors++;
            $display("FAIL reset_mid: out=%0d valid=%b pending=%h lost=%b required all zero", out, valid, pending, lost);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req  = 8'($urandom);
            mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            ack  = $urandom_range(0, 1) == 1;
            en   = $urandom_range(0, 7) != 0;
            tick();
            checks++;
            if (out !== 3'(m_out) || valid !== m_valid || pending !== m_pend || lost !== m_lost) begin
                errors++;
                $display("FAIL random_%0d: out=%0d valid=%b pending=%h lost=%b required %0d/%b/%h/%b",
                         c, out, valid, pending, lost, m_out, m_valid, m_pend, m_lost);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_no_preempt();
        test_mask();
        test_lost();
        test_en_drop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
